median_bram_sampler: RTL

- Downstream consumer of the median-result tile BRAM.
- The BRAM holds a (2*FILTER)x(2*FILTER) tile of median-filtered pixels, stored raster order at address row*N+col, where N=2*FILTER.
- After a tile is written, this block walks every valid centre pixel. For each centre it reads the centre and its 8 radius-RADIUS neighbours through the BRAM read port.
- It presents each 9-sample bundle to the MRELBP code stage with a valid/ready handshake.

---
 rtl/mrelbp_pkg.sv | 35 +++
 rtl/median_sample_addr_gen.sv | 34 +++
 rtl/median_bram_sampler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mrelbp_pkg.sv
// Shared types and constants for the MRELBP front end: sampler FSM states,
// tile geometry helpers and the unit neighbour-offset table.
package mrelbp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_HOLD,
        S_DONE
    } sampler_state_t;

    function automatic int tile_dim(input int filter);
        return 2 * filter;
    endfunction

    function automatic int addr_w(input int filter);
        return $clog2(tile_dim(filter) * tile_dim(filter));
    endfunction

    // Unit offsets for p0..p7, counter-clockwise starting east.
    localparam int NBR_DROW [8] = '{0, -1, -1, -1, 0, 1, 1, 1};
    localparam int NBR_DCOL [8] = '{1, 1, 0, -1, -1, -1, 0, 1};

    function automatic int nbr_drow(input int k, input int radius);
        if (k < 0 || k > 7) return 0;
        return NBR_DROW[k] * radius;
    endfunction

    function automatic int nbr_dcol(input int k, input int radius);
        if (k < 0 || k > 7) return 0;
        return NBR_DCOL[k] * radius;
    endfunction

endpackage

// File: rtl/median_sample_addr_gen.sv
// Maps (centre row, centre col, sample index) to a tile BRAM address.
// Purely combinational; index 0 is the centre, 1..8 are p0..p7.
module median_sample_addr_gen
    import mrelbp_pkg::*;
#(
    parameter int FILTER = 5,
    parameter int RADIUS = 2,
    localparam int N  = tile_dim(FILTER),
    localparam int AW = addr_w(FILTER),
    localparam int CW = $clog2(N)
) (
    input  logic [CW-1:0] row,
    input  logic [CW-1:0] col,
    input  logic [3:0]    idx,
    output logic [AW-1:0] raddr
);

    int dr;
    int dc;
    int a_full;

    always_comb begin
        dr = 0;
        dc = 0;
        if (idx != 4'd0) begin
            dr = nbr_drow(int'(idx) - 1, RADIUS);
            dc = nbr_dcol(int'(idx) - 1, RADIUS);
        end
        // Scan range keeps every tap inside the tile, so no clamping needed.
        a_full = (int'(row) + dr) * N + int'(col) + dc;
        raddr  = AW'(a_full);
    end

endmodule

// File: rtl/median_bram_sampler.sv
// Walks every valid centre of the median tile, fetching centre + 8 neighbours
// from BRAM and presenting each bundle with valid/ready; holds under backpressure.
module median_bram_sampler
    import mrelbp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int FILTER = 5,
    parameter int RADIUS = 2,
    localparam int N  = tile_dim(FILTER),
    localparam int AW = addr_w(FILTER),
    localparam int CW = $clog2(N)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    output logic [AW-1:0]      o_raddr,
    input  logic [WIDTH-1:0]   i_rdata,
    output logic [WIDTH-1:0]   o_center,
    output logic [8*WIDTH-1:0] o_nbr,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_busy,
    output logic               o_done
);

    generate
        if (RADIUS < 1 || RADIUS > (N - 1) / 2) begin : g_bad_radius
            $error("median_bram_sampler: RADIUS out of range for tile");
        end
    endgenerate

    localparam logic [CW-1:0] C_FIRST = CW'(RADIUS);
    localparam logic [CW-1:0] C_LAST  = CW'(N - 1 - RADIUS);

    sampler_state_t state;
    logic [CW-1:0]  row;
    logic [CW-1:0]  col;
    logic [3:0]     idx;
    logic [AW-1:0]  gen_addr;
    logic [AW-1:0]  raddr_q;
    logic           last_centre;

    median_sample_addr_gen #(
        .FILTER(FILTER),
        .RADIUS(RADIUS)
    ) u_addr_gen (
        .row  (row),
        .col  (col),
        .idx  (idx),
        .raddr(gen_addr)
    );

    // Address is live only while issuing; otherwise the last issued one is held.
    assign o_raddr     = (state == S_ISSUE) ? gen_addr : raddr_q;
    assign last_centre = (row == C_LAST) && (col == C_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            row      <= C_FIRST;
            col      <= C_FIRST;
            idx      <= 4'd0;
            raddr_q  <= '0;
            o_center <= '0;
            o_nbr    <= '0;
            o_valid  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        state  <= S_ISSUE;
                        o_busy <= 1'b1;
                        idx    <= 4'd0;
                    end
                end
                S_ISSUE: begin
                    raddr_q <= gen_addr;
                    // Read data for index idx-1 lands this cycle.
                    if (idx == 4'd1) begin
                        o_center <= i_rdata;
                    end else if (idx >= 4'd2) begin
                        o_nbr[(int'(idx) - 2) * WIDTH +: WIDTH] <= i_rdata;
                    end
                    if (idx == 4'd8) begin
                        state <= S_DRAIN;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_DRAIN: begin
                    o_nbr[7*WIDTH +: WIDTH] <= i_rdata;
                    o_valid <= 1'b1;
                    state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        idx     <= 4'd0;
                        if (last_centre) begin
                            row    <= C_FIRST;
                            col    <= C_FIRST;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            if (col == C_LAST) begin
                                col <= C_FIRST;
                                row <= row + CW'(1);
                            end else begin
                                col <= col + CW'(1);
                            end
                            state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    o_done <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
